// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the EX-stage multiply/divide unit.
//   md_op_e      3-bit MD opcode encoding (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, reserved)
//   md_state_e   IDLE/RUN sequencing states
//   MUL_LAT_DEF  default busy cycles for MULT/MULTU
//   DIV_LAT_DEF  default busy cycles for DIV/DIVU
//   div_signed   signed 32-bit divide returning {remainder, quotient}
package md_unit_pkg;

  localparam int unsigned MD_OP_W     = 3;
  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Divides magnitudes, then restores signs: the quotient is negative when the
  // operand signs differ, the remainder follows the dividend. 0x80000000 / -1
  // wraps to 0x80000000 with remainder 0. Divisor must be non-zero.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   start    MD instruction valid in EX this cycle
//   md_op    operation (see md_op_e)
//   rs_data  operand A / dividend / MTHI-MTLO source
//   rt_data  operand B / divisor
//   busy     high while a mult/div is in flight (registered)
//   hi, lo   HI and LO registers
// The result is computed when the op is accepted and held in a pending
// register; HI/LO take it only once the latency countdown expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  md_op_e             op;
  logic               is_mul, is_div, accept_md, accept_mt;
  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        divisor;
  logic [63:0]        result;

  assign op        = md_op_e'(md_op);
  assign is_mul    = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div    = (op == MD_DIV)  || (op == MD_DIVU);
  assign accept_md = start && (state_q == ST_IDLE) && (is_mul || is_div);
  assign accept_mt = start && (state_q == ST_IDLE);

  assign mul_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign mul_u   = {32'd0, rs_data} * {32'd0, rt_data};
  // Keeps the divider defined on a zero divisor; that result is discarded below.
  assign divisor = (rt_data == 32'd0) ? 32'd1 : rt_data;

  always_comb begin
    result = {hi_q, lo_q};
    unique case (op)
      MD_MULT:  result = mul_s;
      MD_MULTU: result = mul_u;
      MD_DIV:   if (rt_data != 32'd0) result = div_signed(rs_data, divisor);
      MD_DIVU:  if (rt_data != 32'd0) result = {rs_data % divisor, rs_data / divisor};
      default:  result = {hi_q, lo_q};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_md)      state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0)    state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_md) begin
          cnt_d  = is_mul ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
          pend_d = result;
        end else if (accept_mt && (op == MD_MTHI)) begin
          hi_d = rs_data;
        end else if (accept_mt && (op == MD_MTLO)) begin
          lo_d = rs_data;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             {hi_d, lo_d} = pend_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Stimulus pushes expected HI/LO
// (from a longint arithmetic model) and expected timing; a negedge monitor
// pops and compares when the DUT completes or the expected cycle arrives.
module tb_md_unit;

  localparam int unsigned MUL_L = 5;
  localparam int unsigned DIV_L = 10;

  localparam int K_MD = 0;  // completes when busy falls
  localparam int K_MT = 1;  // MTHI/MTLO, visible after accept edge
  localparam int K_ST = 2;  // static check: after reset or idle window

  typedef struct {
    int          kind;
    int unsigned stamp;
    int unsigned lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the ISA definitions.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ch,
                                         input logic [31:0] cl);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0]     r;
    r = {ch, cl};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sq = sa * sb; r = sq; end
      3'd2: begin up = {32'd0, a}; up = up * {32'd0, b}; r = up; end
      3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      3'd4: if (b != 0) r = {a % b, a / b};
      default: ;
    endcase
    return r;
  endfunction

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t e;
    logic [63:0] r;
    wait_idle();
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    e.stamp = cyc; e.name = name;
    if (op >= 3'd1 && op <= 3'd4) begin
      r = ref_md(op, a, b, m_hi, m_lo);
      m_hi = r[63:32]; m_lo = r[31:0];
      e.kind = K_MD; e.lat = (op <= 3'd2) ? MUL_L : DIV_L;
      e.hi = m_hi; e.lo = m_lo;
      sbq.push_back(e);
    end else if (op == 3'd5 || op == 3'd6) begin
      if (op == 3'd5) m_hi = a; else m_lo = a;
      e.kind = K_MT; e.lat = 0; e.hi = m_hi; e.lo = m_lo;
      sbq.push_back(e);
    end
  endtask

  // Drives an op in a cycle where the unit is already busy; it must be ignored.
  task automatic issue_busy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
  endtask

  task automatic push_static(input string name);
    exp_t e;
    e.kind = K_ST; e.stamp = cyc; e.lat = 0; e.hi = m_hi; e.lo = m_lo; e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor
  logic        prev_busy = 1'b0;
  logic [31:0] prev_hi = '0, prev_lo = '0;
  bit          armed = 0;
  bit          popped;
  exp_t        f;

  always @(negedge clk) begin
    popped = 0;
    while (sbq.size() > 0 && sbq[0].kind != K_MD && cyc >= sbq[0].stamp) begin
      f = sbq.pop_front();
      chk({f.name, "_busy"}, 32'(busy), 32'd0);
      chk({f.name, "_hi"}, hi, f.hi);
      chk({f.name, "_lo"}, lo, f.lo);
      popped = 1;
    end
    if (!popped && prev_busy && busy === 1'b0) begin
      if (sbq.size() > 0 && sbq[0].kind == K_MD) begin
        f = sbq.pop_front();
        chk({f.name, "_latency"}, cyc - f.stamp, f.lat);
        chk({f.name, "_hi"}, hi, f.hi);
        chk({f.name, "_lo"}, lo, f.lo);
        popped = 1;
      end else begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end
    end
    if (sbq.size() > 0 && sbq[0].kind == K_MD && cyc > sbq[0].stamp + sbq[0].lat + 2) begin
      f = sbq.pop_front();
      chk({f.name, "_completion_timeout"}, 32'(busy), 32'd0);
    end
    if (armed && !popped) begin
      chk("hi_stable", hi, prev_hi);
      chk("lo_stable", lo, prev_lo);
    end
    if (popped) armed = 1;
    prev_busy = busy;
    prev_hi   = hi;
    prev_lo   = lo;
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int unsigned n;

    // Reset
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    push_static("reset");

    // Directed arithmetic cases
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    issue(3'd4, 32'd7, 32'd2, "divu");
    issue(3'd5, 32'h0000_1234, 32'd0, "mthi");
    issue(3'd3, 32'd99, 32'd0, "div_by_zero");
    issue_busy(3'd1, 32'd5, 32'd7);
    issue_busy(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd6, 32'hCAFE_0001, 32'd0, "mtlo");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(3'd4, 32'd5, 32'd0, "divu_by_zero");
    issue(3'd0, 32'h1111_1111, 32'd1, "none");
    issue(3'd7, 32'h2222_2222, 32'd1, "rsvd");
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_min");

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, "rand");
      if ((op >= 3'd1 && op <= 3'd4) && $urandom_range(0, 2) == 0)
        issue_busy(3'($urandom_range(1, 6)), $urandom, $urandom);
    end

    // Reset in the 4th busy cycle of a DIVU: the pending result must never land.
    wait_idle();
    start = 1'b1; md_op = 3'd4; rs_data = 32'd1000; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    push_static("reset_mid_op");
    repeat (10) @(posedge clk);
    #1;
    push_static("after_abort");

    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
